// File: rtl/sound_comm_fifo.sv
// 68k <-> sound 6502 communication port: two independent show-ahead FIFOs with
// occupancy flags, sticky overflow/underflow errors and an NMI to the sound CPU.

module sound_comm_fifo_chan #(
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 4,
  parameter logic [DATA_W-1:0] EMPTY_VAL = 8'hFF,
  parameter int                CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              push_ok,
  output logic              ovf,
  output logic              udf
);
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              empty, pop_ok, push_acc;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign pop_ok   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_acc = push && (!full || pop_ok);
  assign push_ok  = push_acc && !flush;

  always_comb begin
    wr_ptr_d = push_acc ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok   ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_acc) - CNT_W'(pop_ok);
    ovf_d    = ovf_q | (push && !push_acc);
    udf_d    = udf_q | (pop && empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is never cleared; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? EMPTY_VAL : mem_q[rd_ptr_q];
  assign count = count_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;
endmodule

module sound_comm_fifo #(
  parameter int                DATA_W    = 8,
  parameter int                M2S_DEPTH = 4,
  parameter int                S2M_DEPTH = 4,
  parameter int                NMI_MODE  = 0,
  parameter int                NMI_PULSE = 2,
  parameter logic [DATA_W-1:0] EMPTY_VAL = 8'hFF
) (
  input  logic                           SC_2H,
  input  logic                           SNDRST_b,
  input  logic                           main_wr,
  input  logic [DATA_W-1:0]              main_din,
  input  logic                           main_rd,
  output logic [DATA_W-1:0]              main_dout,
  input  logic                           main_flush,
  input  logic                           WR68k_b,
  input  logic [DATA_W-1:0]              SDout,
  input  logic                           RD68k_b,
  output logic [DATA_W-1:0]              SDin68k,
  output logic                           SNDNMI_b,
  output logic                           ctrl_68kBUF,
  output logic                           ctrl_SNDBUF,
  output logic                           m2s_full,
  output logic                           s2m_full,
  output logic [$clog2(M2S_DEPTH+1)-1:0] m2s_count,
  output logic [$clog2(S2M_DEPTH+1)-1:0] s2m_count,
  output logic [3:0]                     err
);
  localparam int NMI_W = $clog2(NMI_PULSE + 1);

  logic             m2s_push_ok, s2m_push_ok;
  logic             m2s_ovf, m2s_udf, s2m_ovf, s2m_udf;
  logic [NMI_W-1:0] nmi_cnt_q, nmi_cnt_d;

  sound_comm_fifo_chan #(
    .DATA_W(DATA_W), .DEPTH(M2S_DEPTH), .EMPTY_VAL(EMPTY_VAL)
  ) u_m2s (
    .clk(SC_2H), .rst_n(SNDRST_b), .flush(main_flush),
    .push(main_wr), .din(main_din), .pop(~RD68k_b),
    .dout(SDin68k), .count(m2s_count), .full(m2s_full),
    .push_ok(m2s_push_ok), .ovf(m2s_ovf), .udf(m2s_udf)
  );

  sound_comm_fifo_chan #(
    .DATA_W(DATA_W), .DEPTH(S2M_DEPTH), .EMPTY_VAL(EMPTY_VAL)
  ) u_s2m (
    .clk(SC_2H), .rst_n(SNDRST_b), .flush(main_flush),
    .push(~WR68k_b), .din(SDout), .pop(main_rd),
    .dout(main_dout), .count(s2m_count), .full(s2m_full),
    .push_ok(s2m_push_ok), .ovf(s2m_ovf), .udf(s2m_udf)
  );

  // Reloading on every accepted write stretches the pulse across back-to-back pushes.
  always_comb begin
    nmi_cnt_d = nmi_cnt_q;
    if (m2s_push_ok)             nmi_cnt_d = NMI_W'(NMI_PULSE);
    else if (nmi_cnt_q != '0)    nmi_cnt_d = nmi_cnt_q - NMI_W'(1);
  end

  always_ff @(posedge SC_2H) begin
    if (!SNDRST_b || main_flush) nmi_cnt_q <= '0;
    else                         nmi_cnt_q <= nmi_cnt_d;
  end

  assign SNDNMI_b    = (NMI_MODE == 1) ? (m2s_count == '0) : (nmi_cnt_q == '0);
  assign ctrl_68kBUF = (m2s_count != '0);
  assign ctrl_SNDBUF = (s2m_count != '0);
  assign err         = {s2m_ovf, s2m_udf, m2s_ovf, m2s_udf};
endmodule

// File: tb/tb_sound_comm_fifo.sv
// Directed bench for sound_comm_fifo: default instance driven from a vector table,
// plus an NMI_MODE=1 / M2S_DEPTH=3 instance exercised by a queue-model sequence.

module tb_sound_comm_fifo;
  logic       clk = 1'b0;
  logic       rst_b, flush, wr, rd, wr68_b, rd68_b;
  logic [7:0] din, sdo;

  logic [7:0] a_dout, a_sdin, b_dout, b_sdin;
  logic       a_nmi, a_c68, a_csnd, a_mfull, a_sfull;
  logic       b_nmi, b_c68, b_csnd, b_mfull, b_sfull;
  logic [2:0] a_mcnt, a_scnt, b_scnt;
  logic [1:0] b_mcnt;
  logic [3:0] a_err, b_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sound_comm_fifo dut_a (
    .SC_2H(clk), .SNDRST_b(rst_b), .main_wr(wr), .main_din(din), .main_rd(rd),
    .main_dout(a_dout), .main_flush(flush), .WR68k_b(wr68_b), .SDout(sdo),
    .RD68k_b(rd68_b), .SDin68k(a_sdin), .SNDNMI_b(a_nmi), .ctrl_68kBUF(a_c68),
    .ctrl_SNDBUF(a_csnd), .m2s_full(a_mfull), .s2m_full(a_sfull),
    .m2s_count(a_mcnt), .s2m_count(a_scnt), .err(a_err)
  );

  sound_comm_fifo #(.M2S_DEPTH(3), .NMI_MODE(1)) dut_b (
    .SC_2H(clk), .SNDRST_b(rst_b), .main_wr(wr), .main_din(din), .main_rd(rd),
    .main_dout(b_dout), .main_flush(flush), .WR68k_b(wr68_b), .SDout(sdo),
    .RD68k_b(rd68_b), .SDin68k(b_sdin), .SNDNMI_b(b_nmi), .ctrl_68kBUF(b_c68),
    .ctrl_SNDBUF(b_csnd), .m2s_full(b_mfull), .s2m_full(b_sfull),
    .m2s_count(b_mcnt), .s2m_count(b_scnt), .err(b_err)
  );

  typedef struct {
    logic       rst_b, flush, wr;
    logic [7:0] din;
    logic       rd68_b, wr68_b;
    logic [7:0] sdo;
    logic       rd;
    logic [7:0] e_sdin;
    int         e_mcnt;
    logic       e_nmi;
    logic [7:0] e_dout;
    int         e_scnt;
    logic [3:0] e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic f, logic w, logic [7:0] d, logic r68, logic w68,
                              logic [7:0] s, logic rr, logic [7:0] es, int em, logic en,
                              logic [7:0] ed, int esc, logic [3:0] ee);
    vec_t v;
    v.rst_b = r; v.flush = f; v.wr = w; v.din = d; v.rd68_b = r68; v.wr68_b = w68;
    v.sdo = s; v.rd = rr; v.e_sdin = es; v.e_mcnt = em; v.e_nmi = en; v.e_dout = ed;
    v.e_scnt = esc; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rst_b = 1'b1; flush = 1'b0; wr = 1'b0; din = 8'h00; rd = 1'b0;
    wr68_b = 1'b1; sdo = 8'h00; rd68_b = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the M2S_DEPTH=3, NMI_MODE=1 instance's m2s side.
  logic [7:0] qb[$];
  logic       mb_ovf = 1'b0, mb_udf = 1'b0;

  task automatic b_step(input logic w, input logic [7:0] d, input logic p, input string nm);
    bit pop_ok, push_ok;
    idle();
    wr = w; din = d; rd68_b = ~p;
    step();
    pop_ok  = p && (qb.size() > 0);
    push_ok = w && ((qb.size() < 3) || pop_ok);
    if (p && qb.size() == 0) mb_udf = 1'b1;
    if (w && !push_ok)       mb_ovf = 1'b1;
    if (pop_ok)  void'(qb.pop_front());
    if (push_ok) qb.push_back(d);
    chk({nm, ".sdin"},  b_sdin, (qb.size() > 0) ? qb[0] : 8'hFF);
    chk({nm, ".count"}, b_mcnt, qb.size());
    chk({nm, ".full"},  b_mfull, qb.size() == 3);
    chk({nm, ".nmi"},   b_nmi, qb.size() == 0);
    chk({nm, ".err"},   b_err[1:0], {mb_ovf, mb_udf});
  endtask

  initial begin
    //            rst fl wr din    r68 w68 sdo    rd   sdin  mc nmi dout  sc err
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'h00, 0,   8'hFF, 0, 1, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 1, 8'h5A, 1, 1, 8'h00, 0,   8'h5A, 1, 0, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 0,   8'h5A, 1, 0, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 0,   8'h5A, 1, 1, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 8'h00, 0,   8'hFF, 0, 1, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 1, 8'h01, 1, 1, 8'h00, 0,   8'h01, 1, 0, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 1, 8'h02, 1, 1, 8'h00, 0,   8'h01, 2, 0, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 1, 8'h03, 1, 1, 8'h00, 0,   8'h01, 3, 0, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 1, 8'h04, 1, 1, 8'h00, 0,   8'h01, 4, 0, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 1, 8'h05, 1, 1, 8'h00, 0,   8'h01, 4, 0, 8'hFF, 0, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 8'h00, 0,   8'h02, 3, 1, 8'hFF, 0, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 8'h00, 0,   8'h03, 2, 1, 8'hFF, 0, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 8'h00, 0,   8'h04, 1, 1, 8'hFF, 0, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 8'h00, 0,   8'hFF, 0, 1, 8'hFF, 0, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h11, 0,   8'hFF, 0, 1, 8'h11, 1, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h22, 0,   8'hFF, 0, 1, 8'h11, 2, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h33, 0,   8'hFF, 0, 1, 8'h11, 3, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h44, 0,   8'hFF, 0, 1, 8'h11, 4, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h77, 1,   8'hFF, 0, 1, 8'h22, 4, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 1,   8'hFF, 0, 1, 8'h33, 3, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 1,   8'hFF, 0, 1, 8'h44, 2, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 1,   8'hFF, 0, 1, 8'h77, 1, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 1,   8'hFF, 0, 1, 8'hFF, 0, 4'h2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h33, 1,   8'hFF, 0, 1, 8'h33, 1, 4'h6));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 1,   8'hFF, 0, 1, 8'hFF, 0, 4'h6));
    tbl.push_back(mk(1, 0, 1, 8'hB1, 1, 1, 8'h00, 0,   8'hB1, 1, 0, 8'hFF, 0, 4'h6));
    tbl.push_back(mk(1, 0, 1, 8'hB2, 1, 1, 8'h00, 0,   8'hB1, 2, 0, 8'hFF, 0, 4'h6));
    tbl.push_back(mk(1, 0, 1, 8'hB3, 1, 1, 8'h00, 0,   8'hB1, 3, 0, 8'hFF, 0, 4'h6));
    tbl.push_back(mk(1, 1, 1, 8'hB4, 1, 0, 8'hC1, 0,   8'hFF, 0, 1, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 0,   8'hFF, 0, 1, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 1, 8'hD1, 1, 1, 8'h00, 0,   8'hD1, 1, 0, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 1, 8'hD2, 1, 1, 8'h00, 0,   8'hD1, 2, 0, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 1, 8'hD3, 1, 1, 8'h00, 1,   8'hD1, 3, 0, 8'hFF, 0, 4'h4));
    tbl.push_back(mk(0, 0, 1, 8'hD4, 1, 0, 8'hC2, 0,   8'hFF, 0, 1, 8'hFF, 0, 4'h0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 0,   8'hFF, 0, 1, 8'hFF, 0, 4'h0));

    idle();
    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("v%0d", i);
      rst_b = tbl[i].rst_b; flush = tbl[i].flush; wr = tbl[i].wr; din = tbl[i].din;
      rd68_b = tbl[i].rd68_b; wr68_b = tbl[i].wr68_b; sdo = tbl[i].sdo; rd = tbl[i].rd;
      step();
      chk({nm, ".sdin"},    a_sdin,  tbl[i].e_sdin);
      chk({nm, ".mcnt"},    a_mcnt,  tbl[i].e_mcnt);
      chk({nm, ".c68kbuf"}, a_c68,   tbl[i].e_mcnt != 0);
      chk({nm, ".mfull"},   a_mfull, tbl[i].e_mcnt == 4);
      chk({nm, ".nmi"},     a_nmi,   tbl[i].e_nmi);
      chk({nm, ".dout"},    a_dout,  tbl[i].e_dout);
      chk({nm, ".scnt"},    a_scnt,  tbl[i].e_scnt);
      chk({nm, ".csndbuf"}, a_csnd,  tbl[i].e_scnt != 0);
      chk({nm, ".sfull"},   a_sfull, tbl[i].e_scnt == 4);
      chk({nm, ".err"},     a_err,   tbl[i].e_err);
    end

    // Level-mode NMI on the depth-3 instance (reset by the last table rows).
    chk("b.reset.nmi", b_nmi, 1'b1);
    b_step(1'b1, 8'hE1, 1'b0, "b.nmi_w1");
    b_step(1'b1, 8'hE2, 1'b0, "b.nmi_w2");
    b_step(1'b0, 8'h00, 1'b1, "b.nmi_p1");
    b_step(1'b0, 8'h00, 1'b1, "b.nmi_p2");

    // Ten pushes through a depth-3 buffer, popping alongside to force repeated wraps.
    for (int i = 0; i < 10; i++)
      b_step(1'b1, 8'h20 + 8'(i), i > 0, $sformatf("b.wrap%0d", i));
    b_step(1'b1, 8'h30, 1'b0, "b.fill0");
    b_step(1'b1, 8'h31, 1'b0, "b.fill1");
    b_step(1'b1, 8'h32, 1'b0, "b.ovf");
    for (int i = 0; i < 4; i++)
      b_step(1'b0, 8'h00, 1'b1, $sformatf("b.drain%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
